// File: rtl/voice_mixer_pwm.sv
// Voice mixer: strobes the voices at the sample rate, sums their offset-binary samples with a
// signed gain shift and saturation, and drives the mixed PCM onto an 8-bit PWM audio pin.
module voice_mixer_pwm #(
    parameter int unsigned NUM_VOICES  = 8,
    parameter int unsigned SAMPLE_DIV  = 2268,
    parameter int unsigned CAPTURE_DLY = 4,
    parameter int unsigned GAIN_SHIFT  = 2
) (
    input  logic                    clk_100mhz,
    input  logic                    rst,
    input  logic [8*NUM_VOICES-1:0] voice_q,
    output logic                    sample_switch,
    output logic                    sample_valid,
    output logic [7:0]              pcm,
    output logic                    pwm_out
);

    localparam int unsigned IdxW     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int unsigned NumSlots = 2 ** IdxW;
    localparam int unsigned AccW     = 8 + $clog2(NUM_VOICES) + 1;
    localparam int unsigned DivW     = $clog2(SAMPLE_DIV);

    localparam logic [DivW-1:0]        DivLast = DivW'(SAMPLE_DIV - 1);
    localparam logic [DivW-1:0]        DivHalf = DivW'(SAMPLE_DIV / 2);
    localparam logic [DivW-1:0]        CapAt   = DivW'(CAPTURE_DLY);
    localparam logic [IdxW-1:0]        IdxLast = IdxW'(NUM_VOICES - 1);
    localparam logic signed [AccW-1:0] SatHi   = 127;
    localparam logic signed [AccW-1:0] SatLo   = -128;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StScale,
        StLoad
    } state_e;

    // ------------------------------------------------------------------
    // Sample-rate divider
    // ------------------------------------------------------------------
    logic [DivW-1:0] div_cnt;
    logic [DivW-1:0] div_next;
    logic            running;

    always_comb begin
        div_next = (div_cnt == DivLast) ? '0 : div_cnt + 1'b1;
    end

    // The first edge after reset only raises sample_switch so that the switch is high exactly
    // while div_cnt < SAMPLE_DIV/2 from then on, with the rise landing on div_cnt == 0.
    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            div_cnt       <= '0;
            running       <= 1'b0;
            sample_switch <= 1'b0;
        end else if (!running) begin
            running       <= 1'b1;
            sample_switch <= 1'b1;
        end else begin
            div_cnt       <= div_next;
            sample_switch <= (div_next < DivHalf);
        end
    end

    // ------------------------------------------------------------------
    // Voice selection and per-voice signed term
    // ------------------------------------------------------------------
    logic [7:0] voices [NumSlots];

    for (genvar g = 0; g < NumSlots; g++) begin : g_voice
        if (g < NUM_VOICES) begin : g_used
            assign voices[g] = voice_q[8*g +: 8];
        end else begin : g_pad
            assign voices[g] = 8'd128;
        end
    end

    logic signed [AccW-1:0] acc;
    logic        [IdxW-1:0] idx;
    logic signed [AccW-1:0] term;
    logic signed [AccW-1:0] shifted;
    logic signed [7:0]      clamped;
    logic signed [7:0]      scaled;
    state_e                 state;

    assign term    = $signed({{(AccW-8){1'b0}}, voices[idx]}) - $signed(AccW'(128));
    assign shifted = acc >>> GAIN_SHIFT;

    always_comb begin
        if (shifted > SatHi) begin
            clamped = 8'sd127;
        end else if (shifted < SatLo) begin
            clamped = -8'sd128;
        end else begin
            clamped = shifted[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Mixing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            state        <= StIdle;
            acc          <= '0;
            idx          <= '0;
            scaled       <= '0;
            pcm          <= 8'd128;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (running && div_cnt == CapAt) begin
                        acc   <= '0;
                        idx   <= '0;
                        state <= StAccum;
                    end
                end
                StAccum: begin
                    acc <= acc + term;
                    idx <= idx + 1'b1;
                    if (idx == IdxLast) begin
                        state <= StScale;
                    end
                end
                StScale: begin
                    scaled <= clamped;
                    state  <= StLoad;
                end
                StLoad: begin
                    // Two's complement to offset binary is just an MSB flip.
                    pcm          <= {~scaled[7], scaled[6:0]};
                    sample_valid <= 1'b1;
                    state        <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // PWM output
    // ------------------------------------------------------------------
    logic [7:0] pcnt;
    logic [7:0] duty;

    // Duty reloads only at the wrap so a PWM period never mixes two duty values.
    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            pcnt    <= 8'd0;
            duty    <= 8'd128;
            pwm_out <= 1'b0;
        end else begin
            pcnt    <= pcnt + 8'd1;
            pwm_out <= (pcnt < duty);
            if (pcnt == 8'd255) begin
                duty <= pcm;
            end
        end
    end

endmodule

// File: tb/tb_voice_mixer_pwm.sv
// Self-checking bench for voice_mixer_pwm: cadence, mixing arithmetic, PWM duty handover,
// mid-accumulation reset and a single-voice unity-gain configuration.
module tb_voice_mixer_pwm;

    localparam int NV    = 8;
    localparam int DIV   = 2268;
    localparam int LAT   = 15;
    localparam int LAT1  = 8;
    localparam int BOUND = 3000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [8*NV-1:0] voice_q = {NV{8'd128}};
    logic          sample_switch;
    logic          sample_valid;
    logic [7:0]    pcm;
    logic          pwm_out;

    logic [7:0]    voice1 = 8'd128;
    logic          sw1;
    logic          sv1;
    logic [7:0]    pcm1;
    logic          pwm1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    voice_mixer_pwm #(
        .NUM_VOICES (NV),
        .SAMPLE_DIV (DIV),
        .CAPTURE_DLY(4),
        .GAIN_SHIFT (2)
    ) dut (
        .clk_100mhz   (clk),
        .rst          (rst),
        .voice_q      (voice_q),
        .sample_switch(sample_switch),
        .sample_valid (sample_valid),
        .pcm          (pcm),
        .pwm_out      (pwm_out)
    );

    voice_mixer_pwm #(
        .NUM_VOICES (1),
        .SAMPLE_DIV (DIV),
        .CAPTURE_DLY(4),
        .GAIN_SHIFT (0)
    ) dut_one (
        .clk_100mhz   (clk),
        .rst          (rst),
        .voice_q      (voice1),
        .sample_switch(sw1),
        .sample_valid (sv1),
        .pcm          (pcm1),
        .pwm_out      (pwm1)
    );

    // Reference: sum of (v-128), floor division by 2^shift, saturate, back to offset binary.
    function automatic int model_mix(input logic [8*NV-1:0] vq, input int nv, input int shift);
        int sum = 0;
        int d;
        int s;
        for (int i = 0; i < nv; i++) sum += int'(vq[8*i +: 8]) - 128;
        d = 1 << shift;
        if (sum >= 0) s = sum / d;
        else s = -((-sum + d - 1) / d);
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s + 128;
    endfunction

    function automatic logic [8*NV-1:0] rand_vec();
        logic [8*NV-1:0] v;
        for (int i = 0; i < NV; i++) v[8*i +: 8] = 8'($urandom_range(0, 255));
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < BOUND && !seen; k++) begin
            step();
            seen = sample_valid;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: sample_valid timeout, got none in %0d cycles, required one", tag, BOUND);
        end
    endtask

    task automatic wait_rise(input string tag);
        bit prev = sample_switch;
        bit seen = 1'b0;
        for (int k = 0; k < BOUND && !seen; k++) begin
            step();
            seen = sample_switch && !prev;
            prev = sample_switch;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: sample_switch rise timeout, got none in %0d cycles, required one",
                     tag, BOUND);
        end
    endtask

    task automatic check_mix(input string tag, input logic [8*NV-1:0] vq, input int exp);
        voice_q = vq;
        wait_valid(tag);
        n_cmp++;
        if (pcm !== 8'(exp)) begin
            n_err++;
            $display("FAIL %s: pcm got %0d, required %0d", tag, pcm, exp);
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        voice_q = {NV{8'd128}};
        voice1  = 8'd128;
        repeat (3) step();
        n_cmp++;
        if (sample_switch !== 1'b0) begin
            n_err++;
            $display("FAIL reset_switch: got %b, required 0", sample_switch);
        end
        n_cmp++;
        if (sample_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid: got %b, required 0", sample_valid);
        end
        n_cmp++;
        if (pcm !== 8'd128) begin
            n_err++;
            $display("FAIL reset_pcm: got %0d, required 128", pcm);
        end
        n_cmp++;
        if (pwm_out !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pwm: got %b, required 0", pwm_out);
        end
        n_cmp++;
        if (pcm1 !== 8'd128 || sw1 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_one: pcm got %0d sw got %b, required 128 and 0", pcm1, sw1);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_cadence();
        int  k = 0;
        int  high = 1;
        int  lat = -1;
        int  nvalid = 0;
        int  ones = 0;
        bit  prev = 1'b1;
        wait_rise("cadence");
        while (k < BOUND) begin
            step();
            k++;
            if (sample_switch && !prev) break;
            if (sample_switch) high++;
            if (sample_valid) begin
                nvalid++;
                lat = k;
            end
            prev = sample_switch;
        end
        n_cmp++;
        if (k !== DIV) begin
            n_err++;
            $display("FAIL cadence_period: got %0d, required %0d", k, DIV);
        end
        n_cmp++;
        if (high !== DIV / 2) begin
            n_err++;
            $display("FAIL cadence_high: got %0d, required %0d", high, DIV / 2);
        end
        n_cmp++;
        if (lat !== LAT) begin
            n_err++;
            $display("FAIL cadence_latency: got %0d, required %0d", lat, LAT);
        end
        n_cmp++;
        if (nvalid !== 1) begin
            n_err++;
            $display("FAIL cadence_valid_count: got %0d, required 1", nvalid);
        end
        n_cmp++;
        if (pcm !== 8'd128) begin
            n_err++;
            $display("FAIL cadence_pcm: got %0d, required 128", pcm);
        end
        repeat (256) begin
            step();
            if (pwm_out) ones++;
        end
        n_cmp++;
        if (ones !== 128) begin
            n_err++;
            $display("FAIL cadence_pwm_high: got %0d, required 128", ones);
        end
    endtask

    task automatic test_mix_directed();
        logic [8*NV-1:0] v;
        int ones;
        check_mix("all_255_clamp", {NV{8'd255}}, 255);
        repeat (300) step();
        ones = 0;
        repeat (256) begin
            step();
            if (pwm_out) ones++;
        end
        n_cmp++;
        if (ones !== 255) begin
            n_err++;
            $display("FAIL pwm_duty_255: high got %0d, required 255", ones);
        end
        check_mix("all_0_clamp", {NV{8'd0}}, 0);
        repeat (300) step();
        ones = 0;
        repeat (256) begin
            step();
            if (pwm_out) ones++;
        end
        n_cmp++;
        if (ones !== 0) begin
            n_err++;
            $display("FAIL pwm_duty_0: high got %0d, required 0", ones);
        end
        v = {NV{8'd128}};
        v[7:0] = 8'd228;
        check_mix("voice0_228", v, 153);
        v[7:0] = 8'd27;
        check_mix("voice0_27_floor", v, 102);
        v = {NV{8'd128}};
        v[31:0] = {4{8'd255}};
        check_mix("exact_127", v, 255);
        v = {NV{8'd128}};
        v[31:0] = {4{8'd0}};
        check_mix("exact_m128", v, 0);
    endtask

    task automatic test_mix_random();
        logic [8*NV-1:0] v;
        repeat (5) begin
            v = rand_vec();
            check_mix("random_mix", v, model_mix(v, NV, 2));
        end
    endtask

    task automatic test_window();
        logic [8*NV-1:0] a;
        logic [7:0] old;
        int exp;
        a   = rand_vec();
        exp = model_mix(a, NV, 2);
        old = pcm;
        voice_q = rand_vec();
        wait_rise("window");
        n_cmp++;
        if (pcm !== old) begin
            n_err++;
            $display("FAIL window_hold: pcm got %0d, required %0d", pcm, old);
        end
        for (int k = 1; k <= LAT; k++) begin
            step();
            if (k == LAT - 1) begin
                n_cmp++;
                if (pcm !== old) begin
                    n_err++;
                    $display("FAIL window_early: pcm got %0d, required %0d", pcm, old);
                end
            end
            voice_q = (k >= 3 && k <= 13) ? a : rand_vec();
        end
        n_cmp++;
        if (sample_valid !== 1'b1 || pcm !== 8'(exp)) begin
            n_err++;
            $display("FAIL window_result: valid got %b pcm got %0d, required 1 and %0d",
                     sample_valid, pcm, exp);
        end
    endtask

    task automatic pwm_transition(input string tag, input logic [8*NV-1:0] v, input int p_old,
                                  input int p_new);
        int len = 0;
        int bad = 0;
        int bad_len = 0;
        int seen_new = 0;
        bit prev;
        bit fell = 1'b0;
        voice_q = v;
        prev = pwm_out;
        for (int k = 0; k < 600 && !fell; k++) begin
            step();
            fell = prev && !pwm_out;
            prev = pwm_out;
        end
        if (!fell) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_sync: pwm_out falling edge not seen in 600 cycles, required one", tag);
        end
        for (int k = 0; k < DIV + 600; k++) begin
            step();
            if (pwm_out) begin
                len++;
            end else if (len > 0) begin
                if (len == p_new) seen_new++;
                else if (len != p_old || seen_new > 0) begin
                    bad++;
                    bad_len = len;
                end
                len = 0;
            end
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL %s_runs: high run of %0d cycles, required %0d then %0d only",
                     tag, bad_len, p_old, p_new);
        end
        n_cmp++;
        if (seen_new == 0) begin
            n_err++;
            $display("FAIL %s_new_duty: runs of %0d got 0, required at least 1", tag, p_new);
        end
        n_cmp++;
        if (pcm !== 8'(p_new)) begin
            n_err++;
            $display("FAIL %s_pcm: got %0d, required %0d", tag, pcm, p_new);
        end
    endtask

    task automatic test_pwm_switch();
        logic [8*NV-1:0] v_lo;
        logic [8*NV-1:0] v_hi;
        v_lo = {NV{8'd128}};
        v_lo[15:0] = 16'h0000;
        v_hi = {NV{8'd128}};
        v_hi[23:0] = {8'd130, 8'd255, 8'd255};
        check_mix("pwm_lo", v_lo, 64);
        repeat (300) step();
        pwm_transition("pwm_up", v_hi, 64, 192);
        wait_valid("pwm_sync");
        pwm_transition("pwm_down", v_lo, 192, 64);
    endtask

    task automatic test_reset_mid();
        logic [8*NV-1:0] v;
        int k = 0;
        int rise1 = -1;
        int rise2 = -1;
        int vk = -1;
        int nvalid = 0;
        logic [7:0] pcm_at;
        bit prev;
        wait_rise("rst_mid");
        repeat (7) step();
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (pcm !== 8'd128 || sample_switch !== 1'b0 || pwm_out !== 1'b0 || sample_valid !== 1'b0)
        begin
            n_err++;
            $display("FAIL rst_mid_outputs: pcm %0d sw %b pwm %b valid %b, required 128 0 0 0",
                     pcm, sample_switch, pwm_out, sample_valid);
        end
        v = rand_vec();
        voice_q = v;
        repeat (3) step();
        @(negedge clk);
        rst = 1'b0;
        prev = sample_switch;
        pcm_at = 8'd0;
        while (k < BOUND && rise2 < 0) begin
            step();
            k++;
            if (sample_switch && !prev) begin
                if (rise1 < 0) rise1 = k;
                else rise2 = k;
            end
            if (sample_valid) begin
                nvalid++;
                if (vk < 0) begin
                    vk = k;
                    pcm_at = pcm;
                end
            end
            prev = sample_switch;
        end
        n_cmp++;
        if (rise1 !== 1) begin
            n_err++;
            $display("FAIL rst_mid_first_rise: got cycle %0d, required 1", rise1);
        end
        n_cmp++;
        if (vk !== 1 + LAT) begin
            n_err++;
            $display("FAIL rst_mid_first_valid: got cycle %0d, required %0d", vk, 1 + LAT);
        end
        n_cmp++;
        if (nvalid !== 1) begin
            n_err++;
            $display("FAIL rst_mid_valid_count: got %0d, required 1", nvalid);
        end
        n_cmp++;
        if (rise2 - rise1 !== DIV) begin
            n_err++;
            $display("FAIL rst_mid_period: got %0d, required %0d", rise2 - rise1, DIV);
        end
        n_cmp++;
        if (pcm_at !== 8'(model_mix(v, NV, 2))) begin
            n_err++;
            $display("FAIL rst_mid_pcm: got %0d, required %0d", pcm_at, model_mix(v, NV, 2));
        end
    endtask

    task automatic test_single_voice();
        logic [7:0] val;
        int exp;
        int k;
        bit seen;
        bit prev;
        seen = 1'b0;
        for (int j = 0; j < BOUND && !seen; j++) begin
            step();
            seen = sv1;
        end
        for (int i = 0; i < 3; i++) begin
            val    = (i == 0) ? 8'd200 : 8'($urandom_range(0, 255));
            exp    = (i == 0) ? 200 : model_mix(64'(val), 1, 0);
            voice1 = val;
            seen   = 1'b0;
            prev   = sw1;
            for (int j = 0; j < BOUND && !seen; j++) begin
                step();
                seen = sw1 && !prev;
                prev = sw1;
            end
            k = 0;
            while (k < 40 && !sv1) begin
                step();
                k++;
            end
            n_cmp++;
            if (!seen || k !== LAT1) begin
                n_err++;
                $display("FAIL single_latency: got %0d (rise seen %b), required %0d", k, seen, LAT1);
            end
            n_cmp++;
            if (pcm1 !== 8'(exp)) begin
                n_err++;
                $display("FAIL single_pcm: got %0d, required %0d", pcm1, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cadence();
        test_mix_directed();
        test_mix_random();
        test_window();
        test_pwm_switch();
        test_reset_mid();
        test_single_voice();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
